alu_seq: RTL and testbench

Sequential command front end for the 64-bit combinational ALU (operands A/B, 5-bit select, carry-in, 64-bit result). It accepts operation commands over a valid/ready interface, drives the ALU operand ports from registers, and waits a programmable settle time. It then captures the result and returns it over a second valid/ready interface. A sweep mode issues every select code from a start value up to the last code, giving the hardware equivalent of a select-sweep stimulus plus result capture.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Constants and state encoding shared by the combinational ALU and its
// sequential command front end.
package alu_pkg;

    localparam int WIDTH = 64;
    localparam int SEL_W = 5;
    // Wait counter is wide enough for ALU_LAT values 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq.sv
// Sequential front end for the combinational ALU: accepts a command, holds the
// operands for ALU_LAT cycles, captures the result and returns it (optionally
// sweeping the select code up to the last value).
module alu_seq #(
    parameter int WIDTH   = alu_pkg::WIDTH,
    parameter int SEL_W   = alu_pkg::SEL_W,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic             cmd_carry,
    input  logic             cmd_sweep,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_carry,
    input  logic [WIDTH-1:0] alu_o,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [SEL_W-1:0] rsp_sel,
    output logic             rsp_last,

    output logic             busy
);
    import alu_pkg::*;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

    state_t             state_q,     state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               sweep_q,     sweep_d;
    logic [WIDTH-1:0]   alu_a_q,     alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,     alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q,   alu_sel_d;
    logic               alu_carry_q, alu_carry_d;
    logic [WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic [SEL_W-1:0]   rsp_sel_q,   rsp_sel_d;
    logic               rsp_last_q,  rsp_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            sweep_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_carry_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cnt_q       <= cnt_d;
            sweep_q     <= sweep_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_carry_q <= alu_carry_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_d     = sweep_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_carry_d = alu_carry_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_last_d  = rsp_last_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_a_d     = cmd_a;
                    alu_b_d     = cmd_b;
                    alu_sel_d   = cmd_sel;
                    alu_carry_d = cmd_carry;
                    sweep_d     = cmd_sweep;
                    cnt_d       = LAT_LOAD;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d = alu_o;
                    rsp_sel_d  = alu_sel_q;
                    // Sweep stops at the last code rather than wrapping.
                    rsp_last_d = !sweep_q || (alu_sel_q == '1);
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        alu_sel_d = alu_sel_q + SEL_W'(1);
                        cnt_d     = LAT_LOAD;
                        state_d   = DRIVE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered so that cmd_ready stays low through reset and the first
    // cycle back in IDLE follows the final handshake edge.
    assign cmd_ready_d = (state_d == IDLE);

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_carry = alu_carry_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq: two instances (ALU_LAT=1 and 4)
// driving a stub ALU, checked against a per-command list of expected responses.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int NDUT = 2;

    typedef struct {
        logic [63:0] data;
        int          sel;
        bit          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n     [NDUT];
    logic             cmd_valid [NDUT];
    logic             cmd_ready [NDUT];
    logic [WIDTH-1:0] cmd_a     [NDUT];
    logic [WIDTH-1:0] cmd_b     [NDUT];
    logic [SEL_W-1:0] cmd_sel   [NDUT];
    logic             cmd_carry [NDUT];
    logic             cmd_sweep [NDUT];
    logic [WIDTH-1:0] alu_a     [NDUT];
    logic [WIDTH-1:0] alu_b     [NDUT];
    logic [SEL_W-1:0] alu_sel   [NDUT];
    logic             alu_carry [NDUT];
    logic [WIDTH-1:0] alu_o     [NDUT];
    logic             rsp_valid [NDUT];
    logic             rsp_ready [NDUT];
    logic [WIDTH-1:0] rsp_data  [NDUT];
    logic [SEL_W-1:0] rsp_sel   [NDUT];
    logic             rsp_last  [NDUT];
    logic             busy      [NDUT];
    logic             glitch    [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            alu_seq #(
                .WIDTH  (WIDTH),
                .SEL_W  (SEL_W),
                .ALU_LAT((gi == 0) ? 1 : 4)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n[gi]),
                .cmd_valid(cmd_valid[gi]),
                .cmd_ready(cmd_ready[gi]),
                .cmd_a    (cmd_a[gi]),
                .cmd_b    (cmd_b[gi]),
                .cmd_sel  (cmd_sel[gi]),
                .cmd_carry(cmd_carry[gi]),
                .cmd_sweep(cmd_sweep[gi]),
                .alu_a    (alu_a[gi]),
                .alu_b    (alu_b[gi]),
                .alu_sel  (alu_sel[gi]),
                .alu_carry(alu_carry[gi]),
                .alu_o    (alu_o[gi]),
                .rsp_valid(rsp_valid[gi]),
                .rsp_ready(rsp_ready[gi]),
                .rsp_data (rsp_data[gi]),
                .rsp_sel  (rsp_sel[gi]),
                .rsp_last (rsp_last[gi]),
                .busy     (busy[gi])
            );
            // Stub ALU; glitch corrupts the result while it must not be sampled.
            assign alu_o[gi] = (alu_a[gi] + alu_b[gi] + WIDTH'(alu_sel[gi]) + WIDTH'(alu_carry[gi]))
                               ^ (glitch[gi] ? 64'hA5A5_0000_FFFF_1234 : 64'h0);
        end
    endgenerate

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input int d, input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready[d]), 0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 0);
        chk({tag, "_rsp_last"},  64'(rsp_last[d]),  0);
        chk({tag, "_busy"},      64'(busy[d]),      0);
        chk({tag, "_alu_a"},     alu_a[d],          0);
        chk({tag, "_alu_b"},     alu_b[d],          0);
        chk({tag, "_alu_sel"},   64'(alu_sel[d]),   0);
        chk({tag, "_alu_carry"}, 64'(alu_carry[d]), 0);
        chk({tag, "_rsp_data"},  rsp_data[d],       0);
        chk({tag, "_rsp_sel"},   64'(rsp_sel[d]),   0);
    endtask

    // Issue one command and consume all its responses.
    //   long_sel : response select that gets a 10-cycle rsp_ready stall
    //   rst_sel  : response select at which reset is asserted (command abandoned)
    //   glitch_on: corrupt the stub ALU output before the expected capture edge
    //   decoy    : present a competing command while busy (must be ignored)
    task automatic run_cmd(input int d, input logic [63:0] a, input logic [63:0] b,
                           input int sel, input bit carry, input bit sweep,
                           input int stall_max, input int long_sel, input int rst_sel,
                           input bit glitch_on, input bit decoy);
        exp_t q[$];
        exp_t e;
        int   lat = lat_of(d);
        int   n;
        int   st;
        int   stalls_total = 0;
        time  t0;

        for (int s = sel; s < 32; s++) begin
            e.data = a + b + 64'(s) + 64'(carry);
            e.sel  = s;
            e.last = !sweep || (s == 31);
            q.push_back(e);
            if (!sweep) break;
        end

        @(negedge clk);
        cmd_valid[d] = 1'b1;
        cmd_a[d]     = a;
        cmd_b[d]     = b;
        cmd_sel[d]   = SEL_W'(sel);
        cmd_carry[d] = carry;
        cmd_sweep[d] = sweep;
        for (int i = 0; i < 20 && cmd_ready[d] !== 1'b1; i++) @(negedge clk);
        chk("accept_ready", 64'(cmd_ready[d]), 1);
        if (cmd_ready[d] !== 1'b1) begin
            cmd_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        t0 = $time;
        #1;
        cmd_valid[d] = decoy;
        cmd_a[d]     = {$urandom, $urandom};
        cmd_b[d]     = {$urandom, $urandom};
        cmd_sel[d]   = SEL_W'($urandom_range(0, 31));
        cmd_carry[d] = ~carry;
        cmd_sweep[d] = ~sweep;
        glitch[d]    = glitch_on;

        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == lat) glitch[d] = 1'b0;
            end while (rsp_valid[d] !== 1'b1 && n < 64);
            chk("latency", 64'(n), 64'(lat + 1));
            chk("rsp_data",  rsp_data[d],        e.data);
            chk("rsp_sel",   64'(rsp_sel[d]),    64'(e.sel));
            chk("rsp_last",  64'(rsp_last[d]),   64'(e.last));
            chk("alu_a",     alu_a[d],           a);
            chk("alu_b",     alu_b[d],           b);
            chk("alu_sel",   64'(alu_sel[d]),    64'(e.sel));
            chk("alu_carry", 64'(alu_carry[d]),  64'(carry));
            chk("busy_cmd_ready", {62'd0, busy[d], cmd_ready[d]}, 64'b10);
            $display("txn dut%0d sel=%0d data=%h last=%0d", d, rsp_sel[d], rsp_data[d], rsp_last[d]);

            if (e.sel == rst_sel) begin
                #2 rst_n[d] = 1'b0;
                #1;
                cmd_valid[d] = 1'b0;
                chk_reset_values(d, "midrst");
                repeat (2) @(negedge clk);
                chk("midrst_hold_valid", 64'(rsp_valid[d]), 0);
                rst_n[d] = 1'b1;
                @(negedge clk);
                chk("midrst_ready_after", 64'(cmd_ready[d]), 1);
                repeat (4) begin
                    @(negedge clk);
                    chk("midrst_no_rsp", {62'd0, rsp_valid[d], busy[d]}, 0);
                end
                return;
            end

            st = (e.sel == long_sel) ? 10 : $urandom_range(0, stall_max);
            stalls_total += st;
            for (int s = 0; s < st; s++) begin
                @(negedge clk);
                chk("stall_valid",     64'(rsp_valid[d]), 1);
                chk("stall_data",      rsp_data[d],       e.data);
                chk("stall_sel",       64'(rsp_sel[d]),   64'(e.sel));
                chk("stall_alu_sel",   64'(alu_sel[d]),   64'(e.sel));
                chk("stall_cmd_ready", 64'(cmd_ready[d]), 0);
            end
            rsp_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready[d] = 1'b0;
            if (e.last) cmd_valid[d] = 1'b0;
        end

        chk("cycles", 64'(($time - t0 - 1) / 10), 64'(q.size() * (lat + 1) + stalls_total));
        @(negedge clk);
        chk("end_idle", {61'd0, busy[d], rsp_valid[d], cmd_ready[d]}, 64'b001);
    endtask

    initial begin
        bit          sw;
        int          d;
        int          s;
        logic [63:0] ra;
        logic [63:0] rb;

        for (int i = 0; i < NDUT; i++) begin
            rst_n[i]     = 1'b0;
            cmd_valid[i] = 1'b0;
            cmd_a[i]     = '0;
            cmd_b[i]     = '0;
            cmd_sel[i]   = '0;
            cmd_carry[i] = 1'b0;
            cmd_sweep[i] = 1'b0;
            rsp_ready[i] = 1'b0;
            glitch[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) chk_reset_values(i, "por");
        for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) chk("por_ready_after", 64'(cmd_ready[i]), 1);

        // Directed: single op, full sweep, sweep boundary, backpressure.
        run_cmd(0, 64'd205, 64'd512, 3,  1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b0);
        run_cmd(0, 64'd205, 64'd512, 0,  1'b1, 1'b1, 0, -1, -1, 1'b0, 1'b0);
        run_cmd(0, 64'd205, 64'd512, 31, 1'b1, 1'b1, 0, -1, -1, 1'b0, 1'b0);
        run_cmd(0, 64'd7,   64'd9,   28, 1'b0, 1'b1, 1, 29, -1, 1'b0, 1'b1);

        // ALU_LAT=4 with a corrupted stub output before the capture edge.
        run_cmd(1, 64'd205, 64'd512, 3,  1'b0, 1'b0, 0, -1, -1, 1'b1, 1'b0);
        run_cmd(1, 64'd1000, 64'd2000, 29, 1'b1, 1'b1, 2, 30, -1, 1'b0, 1'b1);

        // Reset in the middle of a sweep, then confirm recovery.
        run_cmd(0, 64'd205, 64'd512, 0,  1'b1, 1'b1, 0, -1, 10, 1'b0, 1'b0);
        run_cmd(0, 64'd11,  64'd22,  5,  1'b1, 1'b0, 0, -1, -1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            d  = int'($urandom_range(0, 1));
            sw = 1'($urandom_range(0, 1));
            s  = sw ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 31));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_cmd(d, ra, rb, s, 1'($urandom_range(0, 1)), sw, 2, -1, -1,
                    1'($urandom_range(0, 1)) && !sw, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
